// File: rtl/mips_if_fetch_if.sv
// IF-stage signal bundle: imem request/response, minidec hookup, IF/ID buffer and EX redirect.
// The fetch controller takes the master modport; the environment around it takes the slave side.
interface mips_if_fetch_if #(
  parameter int MIPS_ADDR_WIDTH = 32,
  parameter int MIPS_INST_WIDTH = 32
);
  logic                       ifu_req_valid;
  logic                       ifu_req_ready;
  logic [MIPS_ADDR_WIDTH-1:0] ifu_req_addr;
  logic                       ifu_rsp_valid;
  logic [MIPS_INST_WIDTH-1:0] ifu_rsp_inst;

  logic [MIPS_INST_WIDTH-1:0] md_inst;
  logic [MIPS_ADDR_WIDTH-1:0] md_pc_incr;
  logic                       md_dec_j;
  logic                       md_dec_jal;
  logic                       md_dec_jr;
  logic                       md_dec_jalr;
  logic                       md_dec_bxx;
  logic [MIPS_ADDR_WIDTH-1:0] md_dec_j_imm;
  logic [MIPS_ADDR_WIDTH-1:0] md_dec_b_imm;

  logic                       if2id_valid;
  logic                       if2id_ready;
  logic [MIPS_INST_WIDTH-1:0] if2id_inst;
  logic [MIPS_ADDR_WIDTH-1:0] if2id_pc_incr;
  logic                       if2id_prdt_taken;

  logic                       ex_flush_req;
  logic [MIPS_ADDR_WIDTH-1:0] ex_flush_pc;

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    output md_inst, md_pc_incr,
    input  md_dec_j, md_dec_jal, md_dec_jr, md_dec_jalr, md_dec_bxx, md_dec_j_imm, md_dec_b_imm,
    output if2id_valid, if2id_inst, if2id_pc_incr, if2id_prdt_taken,
    input  if2id_ready,
    input  ex_flush_req, ex_flush_pc
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    input  md_inst, md_pc_incr,
    output md_dec_j, md_dec_jal, md_dec_jr, md_dec_jalr, md_dec_bxx, md_dec_j_imm, md_dec_b_imm,
    input  if2id_valid, if2id_inst, if2id_pc_incr, if2id_prdt_taken,
    output if2id_ready,
    output ex_flush_req, ex_flush_pc
  );
endinterface

// File: rtl/mips_if_fetch.sv
// IF fetch controller: owns the PC, one outstanding imem request, 1-entry IF/ID buffer (1 instr / 2 cycles at 1-cycle imem).
// Requests only while the IF/ID slot is free or draining; EX redirects override everything.
module mips_if_fetch #(
  parameter int                         MIPS_ADDR_WIDTH = 32,
  parameter int                         MIPS_INST_WIDTH = 32,
  parameter logic [MIPS_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  mips_if_fetch_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_JRWAIT, S_DROP} state_t;

  localparam logic [MIPS_ADDR_WIDTH-1:0] PC_STEP = MIPS_ADDR_WIDTH'(4);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [MIPS_ADDR_WIDTH-1:0] r_pc;
  logic [MIPS_ADDR_WIDTH-1:0] w_pc_nxt;
  logic [MIPS_ADDR_WIDTH-1:0] w_pc_incr;

  logic                       r_buf_vld;
  logic [MIPS_INST_WIDTH-1:0] r_buf_inst;
  logic [MIPS_ADDR_WIDTH-1:0] r_buf_pc_incr;
  logic                       r_buf_prdt;

  logic                       w_req_vld;
  logic                       w_req_fire;
  logic                       w_load;
  logic                       w_prdt;

  assign w_pc_incr  = r_pc + PC_STEP;
  assign w_req_vld  = (r_state == S_REQ) && (!r_buf_vld || bus.if2id_ready);
  assign w_req_fire = w_req_vld && bus.ifu_req_ready;

  assign bus.ifu_req_valid    = w_req_vld;
  assign bus.ifu_req_addr     = r_pc;
  assign bus.md_inst          = bus.ifu_rsp_inst;
  assign bus.md_pc_incr       = w_pc_incr;
  assign bus.if2id_valid      = r_buf_vld;
  assign bus.if2id_inst       = r_buf_inst;
  assign bus.if2id_pc_incr    = r_buf_pc_incr;
  assign bus.if2id_prdt_taken = r_buf_prdt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_prdt      = 1'b0;
    if (bus.ex_flush_req) begin
      w_pc_nxt = bus.ex_flush_pc;
      // Any request already accepted must have its response swallowed in DROP.
      case (r_state)
        S_WAIT:  w_state_nxt = bus.ifu_rsp_valid ? S_REQ : S_DROP;
        S_REQ:   w_state_nxt = w_req_fire ? S_DROP : S_REQ;
        S_DROP:  w_state_nxt = S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (w_req_fire) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (bus.ifu_rsp_valid) begin
            w_load      = 1'b1;
            w_state_nxt = S_REQ;
            // Static prediction: jumps taken, backward branches taken, jr/jalr wait for EX.
            if (bus.md_dec_j || bus.md_dec_jal) begin
              w_pc_nxt = bus.md_dec_j_imm;
            end else if (bus.md_dec_bxx && (bus.md_dec_b_imm < w_pc_incr)) begin
              w_pc_nxt = bus.md_dec_b_imm;
              w_prdt   = 1'b1;
            end else if (bus.md_dec_jr || bus.md_dec_jalr) begin
              w_state_nxt = S_JRWAIT;
            end else begin
              w_pc_nxt = w_pc_incr;
            end
          end
        end
        S_DROP: begin
          if (bus.ifu_rsp_valid) w_state_nxt = S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_vld     <= 1'b0;
      r_buf_inst    <= '0;
      r_buf_pc_incr <= '0;
      r_buf_prdt    <= 1'b0;
    end else if (bus.ex_flush_req) begin
      r_buf_vld <= 1'b0;
    end else if (w_load) begin
      r_buf_vld     <= 1'b1;
      r_buf_inst    <= bus.ifu_rsp_inst;
      r_buf_pc_incr <= w_pc_incr;
      r_buf_prdt    <= w_prdt;
    end else if (r_buf_vld && bus.if2id_ready) begin
      r_buf_vld <= 1'b0;
    end
  end

endmodule
